// File: rtl/weight_fetch_pkg.sv
// Shared types and default sizing for the per-neuron weight fetch sequencer.
// The entry struct is the default FIFO payload: BRAM address plus returned word.
package weight_fetch_pkg;

    localparam int WF_DEPTH      = 28;
    localparam int WF_AW         = 5;
    localparam int WF_DW         = 16;
    localparam int WF_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } wf_state_t;

    typedef struct packed {
        logic [WF_AW-1:0] index;
        logic [WF_DW-1:0] data;
    } wf_entry_t;

endpackage

// File: rtl/weight_fetch_fifo.sv
// Small register FIFO with push/pop/count and a flush; head entry is always visible.
// Holds whatever payload type it is given and knows nothing about its producer.
module weight_fetch_fifo
    import weight_fetch_pkg::*;
#(
    parameter type entry_t = wf_entry_t,
    parameter int  ENTRIES = WF_FIFO_DEPTH,
    localparam int PW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
    localparam int CW      = $clog2(ENTRIES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    output entry_t        head_data,
    output logic [CW-1:0] count
);

    entry_t             mem_reg [ENTRIES];
    logic [PW-1:0]      wr_ptr_reg;
    logic [PW-1:0]      rd_ptr_reg;
    logic [CW-1:0]      count_reg;
    logic [ENTRIES-1:0] slot_we;
    logic               do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] ptr);
        return (ptr == PW'(ENTRIES - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign do_pop = pop && (count_reg != '0);

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_slot_we
        assign slot_we[gi] = push && !flush && (wr_ptr_reg == PW'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) mem_reg[i] <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (slot_we[i]) mem_reg[i] <= push_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)   wr_ptr_reg <= bump(wr_ptr_reg);
            if (do_pop) rd_ptr_reg <= bump(rd_ptr_reg);
            case ({push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // The producer's credit scheme must make a push into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(push && !do_pop && count_reg == CW'(ENTRIES)));
        end
    end

    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Streams weights 0..DEPTH-1 out of a falling-edge BRAM into a valid/ready MAC lane.
// A read is issued only when the buffer is guaranteed room for its returning word.
module weight_fetch_ctrl
    import weight_fetch_pkg::*;
#(
    parameter int DEPTH      = WF_DEPTH,
    parameter int AW         = WF_AW,
    parameter int DW         = WF_DW,
    parameter int FIFO_DEPTH = WF_FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] bram_addr,
    output logic          bram_en,
    output logic          bram_we,
    input  logic [DW-1:0] bram_do,
    output logic [DW-1:0] w_data,
    output logic          w_valid,
    input  logic          w_ready,
    output logic          w_last,
    output logic [AW-1:0] w_index
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [AW-1:0] index;
        logic [DW-1:0] data;
    } entry_t;

    wf_state_t     state_reg, state_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic          en_reg, en_next;
    logic          done_reg, done_next;

    entry_t        push_entry;
    entry_t        head_entry;
    logic [CW-1:0] fifo_count;
    logic          pop;
    logic          credit_ok;

    // Word read in an issue cycle lands on the falling edge and is captured at the closing rising edge.
    assign push_entry.index = addr_reg;
    assign push_entry.data  = bram_do;

    weight_fetch_fifo #(
        .entry_t (entry_t),
        .ENTRIES (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .push      (en_reg),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (fifo_count)
    );

    assign w_valid = (fifo_count != '0);
    assign pop     = w_valid && w_ready;
    assign w_data  = head_entry.data;
    assign w_index = head_entry.index;
    assign w_last  = w_valid && (head_entry.index == AW'(DEPTH - 1));

    // Occupancy after this edge plus the word still in flight must leave a free slot.
    assign credit_ok = (int'(fifo_count) - int'(pop) + int'(en_reg)) < FIFO_DEPTH;

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        en_next    = 1'b0;
        done_next  = 1'b0;
        if (abort) begin
            state_next = IDLE;
            addr_next  = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        en_next    = 1'b1;
                        addr_next  = '0;
                        state_next = (DEPTH == 1) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (credit_ok) begin
                        en_next   = 1'b1;
                        addr_next = addr_reg + 1'b1;
                        if (addr_reg == AW'(DEPTH - 2)) state_next = DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && w_last) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            en_reg    <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            en_reg    <= en_next;
            done_reg  <= done_next;
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign bram_addr = addr_reg;
    assign bram_en   = en_reg;
    assign bram_we   = 1'b0;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl against a falling-edge BRAM holding 0x0100+k.
// Inputs change 1 time unit after a rising edge; outputs are checked at that point.
module tb_weight_fetch_ctrl;

    localparam int DEPTH = 28;
    localparam int AW    = 5;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] bram_addr;
    logic          bram_en;
    logic          bram_we;
    logic [DW-1:0] bram_do;
    logic [DW-1:0] w_data;
    logic          w_valid;
    logic          w_ready;
    logic          w_last;
    logic [AW-1:0] w_index;

    int tests = 0;
    int fails = 0;

    weight_fetch_ctrl #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .DW         (DW),
        .FIFO_DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .bram_addr (bram_addr),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_do   (bram_do),
        .w_data    (w_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_last    (w_last),
        .w_index   (w_index)
    );

    always #5 clk = ~clk;

    // Falling-edge single-port BRAM preloaded with word k = 0x0100 + k.
    always @(negedge clk) begin
        if (bram_en) bram_do <= 16'h0100 + 16'(bram_addr);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            step();
            if (done) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    // Full stream with a scoreboard; mode 0 = ready always high, mode 1 = ready toggling.
    task automatic stream_run(input string tag, input int mode, input int repulse_at);
        int exp_idx = 0;
        int issued  = 0;
        int popped  = 0;
        int max_out = 0;
        int cyc     = 0;
        bit seen    = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        while (!seen && cyc < 400) begin
            if (bram_en) issued++;
            if (issued - popped > max_out) max_out = issued - popped;
            w_ready = (mode == 0) ? 1'b1 : ~cyc[0];
            start   = (cyc == repulse_at);
            if (w_valid && w_ready) begin
                chk({tag, "_data"},  32'(w_data),  32'h0100 + 32'(exp_idx));
                chk({tag, "_index"}, 32'(w_index), 32'(exp_idx));
                chk({tag, "_last"},  32'(w_last),  32'(exp_idx == DEPTH - 1));
                exp_idx++;
                popped++;
            end
            step();
            cyc++;
            if (done) seen = 1'b1;
        end
        start   = 1'b0;
        w_ready = 1'b1;
        chk({tag, "_count"},       32'(exp_idx),      32'(DEPTH));
        chk({tag, "_done"},        32'(seen),         32'd1);
        chk({tag, "_outstanding"}, 32'(max_out <= 2), 32'd1);
        chk({tag, "_busy_low"},    32'(busy),         32'd0);
        step();
        chk({tag, "_done_pulse"},  32'(done),         32'd0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"},   32'(busy),      32'd0);
        chk({tag, "_done"},   32'(done),      32'd0);
        chk({tag, "_en"},     32'(bram_en),   32'd0);
        chk({tag, "_addr"},   32'(bram_addr), 32'd0);
        chk({tag, "_we"},     32'(bram_we),   32'd0);
        chk({tag, "_valid"},  32'(w_valid),   32'd0);
        chk({tag, "_last"},   32'(w_last),    32'd0);
        chk({tag, "_index"},  32'(w_index),   32'd0);
        chk({tag, "_data"},   32'(w_data),    32'd0);
    endtask

    initial begin
        int en_cnt;
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        w_ready = 1'b1;
        step();
        step();
        chk_reset_values("reset");
        rst = 1'b0;
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // Exact timing of a full stream with ready held high.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t1_busy",      32'(busy),      32'd1);
        chk("t1_en0",       32'(bram_en),   32'd1);
        chk("t1_addr0",     32'(bram_addr), 32'd0);
        chk("t1_valid0",    32'(w_valid),   32'd0);
        for (int k = 0; k < DEPTH; k++) begin
            step();
            chk("t1_valid", 32'(w_valid), 32'd1);
            chk("t1_data",  32'(w_data),  32'h0100 + 32'(k));
            chk("t1_index", 32'(w_index), 32'(k));
            chk("t1_last",  32'(w_last),  32'(k == DEPTH - 1));
            chk("t1_done",  32'(done),    32'd0);
            chk("t1_en",    32'(bram_en), 32'(k < DEPTH - 1));
            if (k < DEPTH - 1) chk("t1_addr", 32'(bram_addr), 32'(k + 1));
        end
        step();
        chk("t1_valid_end", 32'(w_valid), 32'd0);
        chk("t1_done_end",  32'(done),    32'd1);
        chk("t1_busy_end",  32'(busy),    32'd0);
        step();
        chk("t1_done_once", 32'(done),    32'd0);

        // Ready toggling every cycle.
        stream_run("t2", 1, -1);

        // Back-pressure from the start: two reads, then hold.
        w_ready = 1'b0;
        start   = 1'b1;
        step();
        start  = 1'b0;
        en_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (bram_en) begin
                chk("t3_addr", 32'(bram_addr), 32'(en_cnt));
                en_cnt++;
            end
            if (w_valid) chk("t3_hold_data", 32'(w_data), 32'h0100);
            step();
        end
        chk("t3_en_count", 32'(en_cnt),  32'd2);
        chk("t3_valid",    32'(w_valid), 32'd1);
        chk("t3_index",    32'(w_index), 32'd0);
        w_ready = 1'b1;
        step();
        chk("t3_resume_en",   32'(bram_en),   32'd1);
        chk("t3_resume_addr", 32'(bram_addr), 32'd2);
        chk("t3_next_data",   32'(w_data),    32'h0101);
        wait_done("t3_done");
        step();

        // Abort after five handshakes, then restart from address 0.
        w_ready = 1'b1;
        start   = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 5; i++) step();
        chk("t4_pre_index", 32'(w_index), 32'd5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_busy",  32'(busy),    32'd0);
        chk("t4_valid", 32'(w_valid), 32'd0);
        chk("t4_en",    32'(bram_en), 32'd0);
        chk("t4_done",  32'(done),    32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_no_done", 32'(done), 32'd0);
        end
        stream_run("t4_restart", 0, -1);

        // START re-pulsed while streaming must not restart.
        stream_run("t5_repulse", 0, 8);

        // ABORT and START together mid-stream: abort wins.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("t5_abst_busy",  32'(busy),    32'd0);
        chk("t5_abst_valid", 32'(w_valid), 32'd0);
        chk("t5_abst_en",    32'(bram_en), 32'd0);
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("t5_idle_abst_busy", 32'(busy),    32'd0);
        chk("t5_idle_abst_en",   32'(bram_en), 32'd0);

        // Asynchronous reset mid-stream.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("t5_rst_pre_valid", 32'(w_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_values("t5_rst_async");
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_rst_no_done",  32'(done),    32'd0);
            chk("t5_rst_no_valid", 32'(w_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/weight_fetch_ctrl.md
# weight_fetch_ctrl

Read-side sequencer for one neuron's weight BRAM. On START it walks addresses 0..DEPTH-1 of a single-port 16-bit weight memory, which samples and updates its output on the falling clock edge. It buffers the returned words in a small FIFO and presents them to the neuron MAC as a valid/ready stream with a last-word flag. One instance sits between each weight BRAM and its MAC lane in the ANN datapath.

## Interface
- DEPTH, 28, number of weights per neuron (BRAM words 0..DEPTH-1)
- AW, 5, address width; must satisfy 2**AW >= DEPTH
- DW, 16, weight word width
- FIFO_DEPTH, 2, output buffer entries; must be >= 2
- CLK  in  1  single clock; all control logic is rising-edge
- RST  in  1  reset, asynchronous and active-high
- START  in  1  one-cycle request to stream all weights; ignored unless idle
- ABORT  in  1  synchronous cancel; flushes and returns to idle
- BUSY  out  1  high from the cycle after START is accepted until DONE or abort
- DONE  out  1  one-cycle pulse after the final word handshake
- BRAM_ADDR  out  AW  read address to the BRAM ADDR port
- BRAM_EN  out  1  BRAM enable
- BRAM_WE  out  1  constant 0; this block never writes
- BRAM_DO  in  DW  BRAM read data
- W_DATA  out  DW  weight word, FIFO head
- W_VALID  out  1  W_DATA valid
- W_READY  in  1  consumer accepts the word when W_VALID && W_READY at a rising edge
- W_LAST  out  1  high with W_VALID for word index DEPTH-1
- W_INDEX  out  AW  BRAM address of the word currently at the FIFO head

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE: if START is high at a rising edge, go to RUN with issue address 0. BUSY=1 from that edge onward.
- RUN: issue one read per cycle when credit is available; after issuing address DEPTH-1, go to DRAIN.
- DRAIN: no issues. When the word with W_LAST is handshaken, pulse DONE for one cycle, go to IDLE, and drop BUSY in the same edge.
- Credit rule: issue in a cycle only if (fifo_count − pop_this_cycle + inflight) < FIFO_DEPTH. inflight is 1 if a read was issued in the previous cycle. W_READY held high must give one word per cycle.
- Issue: BRAM_EN=1 and BRAM_ADDR=k, both registered and updated at a rising edge. Address increments by 1 and never wraps past DEPTH-1. BRAM_EN=0 in every non-issue cycle.
- Capture: BRAM_DO is written into the FIFO at the rising edge that ends the issue cycle. The falling edge inside that cycle produces the data. The word index is stored alongside the data.
- W_LAST = W_VALID && (head index == DEPTH-1).
- START while BUSY is ignored, with no restart and no error.
- ABORT (any state): at the next edge, empty the FIFO, drop inflight, set BRAM_EN=0, clear BUSY, go to IDLE, no DONE. ABORT wins over a simultaneous START.
- Push and pop in the same cycle are legal, and the count is unchanged. The FIFO never overflows by construction; an overflow is an assertion failure.

## Timing
- Reset values (asynchronous): state=IDLE, BRAM_ADDR=0, BRAM_EN=0, BRAM_WE=0, W_VALID=0, W_LAST=0, W_INDEX=0, W_DATA=0, BUSY=0, DONE=0, FIFO empty. Reset mid-stream discards everything, and no DONE follows.
- Edge E0 samples START → from E0: BRAM_EN=1, ADDR=0 → E1 captures word 0 → W_VALID=1 from E1.
- Streaming with W_READY=1 throughout: W_VALID stays high for exactly DEPTH consecutive cycles (E1..E28 for DEPTH=28). DONE is high for the cycle after the last handshake edge, and BUSY falls at the same edge.
- Back-pressure: with W_READY=0, at most FIFO_DEPTH words are buffered, with no BRAM_EN while the buffer is full. W_DATA, W_INDEX and W_LAST stay stable while W_VALID && !W_READY.
- Minimum START-to-DONE: DEPTH+1 cycles.

## Structure
- Package weight_fetch_pkg: FSM state enum (IDLE, RUN, DRAIN), default DEPTH/AW/DW constants, and the FIFO entry struct {index, data}.
- Sub-module weight_fetch_fifo: synchronous FIFO_DEPTH-entry register FIFO with push/pop/count, async active-high reset. It holds no BRAM or FSM knowledge.
- Top: FSM, address counter, credit logic, DONE pulse register.

## Test plan
- BRAM model preloaded with word k = 16'h0100+k, W_READY=1, START pulse → 28 consecutive words 0x0100..0x011B, W_INDEX 0..27, W_LAST only on 0x011B, DONE one cycle later, BUSY low after.
- W_READY toggling 1/0 every cycle → all 28 words in order with no duplicates or loss, and never more than 2 reads outstanding plus buffered.
- W_READY=0 for 10 cycles after START → exactly 2 BRAM_EN pulses (addresses 0 and 1) then EN low. W_DATA=0x0100 held stable. Releasing READY resumes at address 2.
- ABORT asserted after 5 handshakes → next cycle BUSY=0, W_VALID=0, BRAM_EN=0, no DONE. A new START streams again from address 0.
- START re-pulsed during streaming, ABORT+START in the same cycle, and RST asserted mid-stream → no restart, the abort wins, and all outputs go to their reset values immediately with no DONE.
